// File: rtl/twiddle_generator.sv
// rtl/twiddle_generator.sv - streaming radix-2 DIF twiddle source
// Rebuilds W_N^k from a quarter-wave cosine table by symmetry, one item per handshake.
module twiddle_generator #(
  parameter int LOG2N  = 4,
  parameter int NB_TW  = 17,
  parameter int NBF_TW = 15
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic signed [NB_TW-1:0] o_tw_real,
  output logic signed [NB_TW-1:0] o_tw_imag,
  output logic [LOG2N-1:0]        o_stage,
  output logic                    o_stage_last,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int N  = 1 << LOG2N;
  localparam int Q  = N / 4;
  localparam int BW = LOG2N - 1;
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  // Table contents are fixed at elaboration: round(cos(2*pi*i/N) * 2^NBF_TW), i = 0..N/4.
  function automatic logic signed [NB_TW-1:0] cos_q(input int i);
    real x, term, sum;
    x    = 6.283185307179586 * real'(i) / real'(N);
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n <= 24; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return NB_TW'($rtoi(sum * real'(longint'(1) << NBF_TW) + 0.5));
  endfunction

  logic signed [NB_TW-1:0] rom [0:Q];

  for (genvar gi = 0; gi <= Q; gi++) begin : g_rom
    localparam logic signed [NB_TW-1:0] C = cos_q(gi);
    assign rom[gi] = C;
  end

  state_t                  state, state_n;
  logic [LOG2N-1:0]        cur_s, cur_s_n;
  logic [BW-1:0]           cur_b, cur_b_n;
  logic [BW-1:0]           mask, cur_k, m_idx;
  logic signed [NB_TW-1:0] item_re, item_im;
  logic                    item_stage_last, item_last;
  logic                    load;
  logic                    valid_n, stage_last_n, last_n, done_n;
  logic signed [NB_TW-1:0] re_n, im_n;
  logic [LOG2N-1:0]        stage_n;

  // cur_s/cur_b always point at the item the output register loads next.
  always_comb begin
    mask  = BW'((N >> (int'(cur_s) + 1)) - 1);
    cur_k = (cur_b & mask) << cur_s;
    m_idx = '0;
    if (cur_k <= BW'(Q)) begin
      item_re = rom[cur_k];
      item_im = -rom[BW'(Q) - cur_k];
    end else begin
      m_idx   = cur_k - BW'(Q);
      item_re = -rom[BW'(Q) - m_idx];
      item_im = -rom[m_idx];
    end
  end

  assign item_stage_last = (cur_b == '1);
  assign item_last       = item_stage_last && (cur_s == LAST_STAGE);

  always_comb begin
    state_n      = state;
    cur_s_n      = cur_s;
    cur_b_n      = cur_b;
    valid_n      = o_valid;
    re_n         = o_tw_real;
    im_n         = o_tw_imag;
    stage_n      = o_stage;
    stage_last_n = o_stage_last;
    last_n       = o_last;
    done_n       = 1'b0;
    load         = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) begin
          state_n = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (!o_valid || i_ready) begin
          if (o_valid && o_last) begin
            state_n      = IDLE;
            valid_n      = 1'b0;
            re_n         = '0;
            im_n         = '0;
            stage_n      = '0;
            stage_last_n = 1'b0;
            last_n       = 1'b0;
            done_n       = 1'b1;
            cur_s_n      = '0;
            cur_b_n      = '0;
          end else begin
            load = 1'b1;
          end
        end
      end
    endcase

    if (load) begin
      valid_n      = 1'b1;
      re_n         = item_re;
      im_n         = item_im;
      stage_n      = cur_s;
      stage_last_n = item_stage_last;
      last_n       = item_last;
      cur_b_n      = cur_b + 1'b1;
      if (item_last) begin
        cur_s_n = '0;
      end else if (item_stage_last) begin
        cur_s_n = cur_s + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cur_s        <= '0;
      cur_b        <= '0;
      o_valid      <= 1'b0;
      o_tw_real    <= '0;
      o_tw_imag    <= '0;
      o_stage      <= '0;
      o_stage_last <= 1'b0;
      o_last       <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state        <= state_n;
      cur_s        <= cur_s_n;
      cur_b        <= cur_b_n;
      o_valid      <= valid_n;
      o_tw_real    <= re_n;
      o_tw_imag    <= im_n;
      o_stage      <= stage_n;
      o_stage_last <= stage_last_n;
      o_last       <= last_n;
      o_busy       <= (state_n == RUN);
      o_done       <= done_n;
    end
  end

endmodule
